// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: the controller
// state encoding and a helper that sizes the bit counter for a given width.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Bits needed to count 0..width-1; never less than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor_1_bit.sv
// One-bit full subtractor: D = A - B - BIN, BOUT is the borrow out.
// Purely combinational; the serial subtractor reuses one instance per bit.
module full_subtractor_1_bit (
   input  logic A,
   input  logic B,
   input  logic BIN,
   output logic D,
   output logic BOUT
);

   // Difference bit and borrow out of a single bit position.
   always_comb begin
      D    = A ^ B ^ BIN;
      BOUT = (~A & B) | (~(A ^ B) & BIN);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor DIFF = A - B (mod 2^WIDTH), LSB first, one
// bit per clock through a single full-subtractor cell and a registered borrow.
// START/BUSY/DONE handshake; DIFF/BOUT hold until the next completion.
// Optional build macro SERIAL_SUB_OVF_EN adds the OVF output (signed
// two's-complement overflow of A - B), using sign bits captured at START.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_d_sh;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;
   logic             w_d;
   logic             w_br_next;
   logic             w_accept;
   logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
`endif

   full_subtractor_1_bit u_fs (
      .A    (r_a_sh[0]),
      .B    (r_b_sh[0]),
      .BIN  (r_br),
      .D    (w_d),
      .BOUT (w_br_next)
   );

   // START only counts while idle; the last shift is the one at cnt == WIDTH-1.
   assign w_accept = (r_state == IDLE) && START;
   assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; FINISH always returns to IDLE so START there is ignored.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (START) w_next = SHIFT;
         SHIFT:   if (r_cnt == LAST_CNT) w_next = FINISH;
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture on accepted START, then one bit per clock while shifting.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_d_sh  <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a_sh  <= A;
         r_b_sh  <= B;
         r_d_sh  <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb <= A[WIDTH-1];
         r_b_msb <= B[WIDTH-1];
`endif
      end else if (r_state == SHIFT) begin
         r_a_sh <= r_a_sh >> 1;
         r_b_sh <= r_b_sh >> 1;
         r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
         r_br   <= w_br_next;
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   // Registered handshake and result; DIFF/BOUT only move on the final shift.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         BUSY <= 1'b0;
         DONE <= 1'b0;
         DIFF <= '0;
         BOUT <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         OVF  <= 1'b0;
`endif
      end else begin
         BUSY <= (w_next == SHIFT);
         DONE <= (w_next == FINISH);
         if (w_last) begin
            DIFF <= {w_d, r_d_sh[WIDTH-1:1]};
            BOUT <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: operand signs differ and result sign differs from A.
            OVF  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios followed by
// random traffic, all compared every cycle against a transaction-level model.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] DIFF;
   logic             BOUT;
`ifdef SERIAL_SUB_OVF_EN
   logic             OVF;
`endif

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DIFF  (DIFF),
      .BOUT  (BOUT)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .OVF   (OVF)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: m_ph counts edges since the accepted START
   // (0 = idle, 1..WIDTH = busy, WIDTH+1 = done cycle).
   int               m_ph;
   logic [WIDTH-1:0] m_a;
   logic [WIDTH-1:0] m_b;
   logic [WIDTH-1:0] m_diff;
   logic             m_bout;
   logic             m_ovf;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph   = 0;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_edge();
      int sa, sb, sr;
      if (m_ph == 0) begin
         if (START === 1'b1) begin
            m_ph = 1;
            m_a  = A;
            m_b  = B;
         end
      end else if (m_ph == WIDTH + 1) begin
         m_ph = 0;
      end else begin
         m_ph++;
         if (m_ph == WIDTH + 1) begin
            m_diff = m_a - m_b;
            m_bout = (m_a < m_b);
            sa = int'($signed(m_a));
            sb = int'($signed(m_b));
            sr = sa - sb;
            m_ovf = (sr < -(2 ** (WIDTH - 1))) || (sr > (2 ** (WIDTH - 1)) - 1);
         end
      end
   endtask

   task automatic check_outputs(input string ctx);
      check_val({ctx, ".busy"}, BUSY, (m_ph >= 1) && (m_ph <= WIDTH));
      check_val({ctx, ".done"}, DONE, (m_ph == WIDTH + 1));
      check_val({ctx, ".diff"}, DIFF, m_diff);
      check_val({ctx, ".bout"}, BOUT, m_bout);
`ifdef SERIAL_SUB_OVF_EN
      check_val({ctx, ".ovf"}, OVF, m_ovf);
`endif
   endtask

   // One clock: model follows the edge (inputs are stable there), outputs checked 1ns later.
   task automatic tick(input string ctx = "cyc");
      @(posedge CLK);
      if (RST_N === 1'b1) model_edge();
      #1;
      check_outputs(ctx);
   endtask

   // Asynchronous reset between edges, held for n edges, released between edges.
   task automatic do_reset(input int n);
      RST_N = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_async");
      repeat (n) tick("rst_hold");
      RST_N = 1'b1;
   endtask

   // Start one operation, scramble the inputs afterwards, run to the DONE cycle.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      START = 1'b1;
      A = a;
      B = b;
      tick("op_start");
      START = 1'b0;
      A = WIDTH'($urandom);
      B = WIDTH'($urandom);
      repeat (WIDTH) tick("op_run");
      check_val("op_done_pulse", DONE, 1);
   endtask

   initial begin
      RST_N = 1'b0;
      START = 1'b0;
      A = '0;
      B = '0;
      model_reset();
      #2;
      check_outputs("reset");
      #10;
      RST_N = 1'b1;

      // 5 - 3
      run_op(4'd5, 4'd3);
      check_val("t1_diff", DIFF, 2);
      check_val("t1_bout", BOUT, 0);
      tick();

      // 3 - 5 wraps
      run_op(4'd3, 4'd5);
      check_val("t2_diff", DIFF, 14);
      check_val("t2_bout", BOUT, 1);
`ifdef SERIAL_SUB_OVF_EN
      check_val("t2_ovf", OVF, 0);
`endif
      tick();

      // 15 - 15 then 0 - 0, second START in the first IDLE cycle
      run_op(4'd15, 4'd15);
      check_val("t3a_diff", DIFF, 0);
      check_val("t3a_bout", BOUT, 0);
      tick();
      run_op(4'd0, 4'd0);
      check_val("t3b_diff", DIFF, 0);
      check_val("t3b_bout", BOUT, 0);
      tick();

      // -8 - 1 overflows in signed terms
      run_op(4'd8, 4'd1);
      check_val("t4_diff", DIFF, 7);
      check_val("t4_bout", BOUT, 0);
`ifdef SERIAL_SUB_OVF_EN
      check_val("t4_ovf", OVF, 1);
`endif
      tick();

      // START held high, operands changing during the shift
      START = 1'b1;
      A = 4'd9;
      B = 4'd4;
      tick("t5_start");
      for (int i = 0; i < WIDTH; i++) begin
         A = WIDTH'($urandom);
         B = WIDTH'($urandom);
         tick("t5_run");
      end
      check_val("t5_diff", DIFF, 5);
      tick("t5_finish");
      check_val("t5_no_extra_done", DONE, 0);
      tick("t5_resample");
      START = 1'b0;
      repeat (WIDTH + 2) tick("t5_drain");

      // Reset two cycles into an operation
      START = 1'b1;
      A = 4'd6;
      B = 4'd2;
      tick("t6_start");
      START = 1'b0;
      tick("t6_run");
      tick("t6_run");
      do_reset(2);
      check_val("t6_busy_rst", BUSY, 0);
      check_val("t6_diff_rst", DIFF, 0);
      repeat (WIDTH + 2) tick("t6_quiet");
      run_op(4'd6, 4'd2);
      check_val("t6_diff", DIFF, 4);
      check_val("t6_bout", BOUT, 0);
      tick();

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         START = ($urandom_range(0, 2) == 0);
         A = WIDTH'($urandom);
         B = WIDTH'($urandom);
         if ($urandom_range(0, 80) == 0) do_reset($urandom_range(1, 3));
         else tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
